// File: rtl/bcd_sub_serial.sv
// Digit-serial packed-BCD |a-b| with sign via nines-complement add; `BCD_SUB_ADD_MODE_EN adds op/ovf for plain BCD add.
// Latency: accepted start on edge E -> done high after edge E+2*DIGITS+1, regardless of sign or mode.
// Backpressure: none; start is sampled only in IDLE and ignored while busy or during the done cycle.
module bcd_sub_serial #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  start,
`ifdef BCD_SUB_ADD_MODE_EN
  input  logic                  op,
  output logic                  ovf,
`endif
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   diff,
  output logic                  neg,
  output logic                  invalid
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [2:0] {IDLE, ADD, FIX, FIN, DONE} state_t;

  state_t         state, state_n;
  logic [W-1:0]   ra, rb, r;
  logic [IW-1:0]  idx;
  logic           carry, cout, rej_q, op_q;
  logic           ops_ok, accept, reject, last;
  logic [4:0]     add_res, fix_res;
  logic [3:0]     b_dig;

  function automatic logic all_bcd(input logic [W-1:0] v);
    for (int i = 0; i < DIGITS; i++)
      if (v[4*i +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  // Single decimal digit add: returns {carry, digit}.
  function automatic logic [4:0] dadd(input logic [3:0] x, input logic [3:0] y, input logic c);
    logic [4:0] s;
    s = {1'b0, x} + {1'b0, y} + {4'd0, c};
    if (s > 5'd9) return {1'b1, 4'(s - 5'd10)};
    return {1'b0, s[3:0]};
  endfunction

  // Operands and result shift right one digit per cycle; new digits enter at the MSD.
  function automatic logic [W-1:0] push_msd(input logic [W-1:0] v, input logic [3:0] d);
    logic [W-1:0] t;
    t = v >> 4;
    t[W-1 -: 4] = d;
    return t;
  endfunction

  assign ops_ok  = all_bcd(a) && all_bcd(b);
  assign accept  = (state == IDLE) && start && ops_ok;
  assign reject  = (state == IDLE) && start && !ops_ok;
  assign last    = (idx == IW'(DIGITS - 1));
  assign b_dig   = op_q ? rb[3:0] : (4'd9 - rb[3:0]);
  assign add_res = dadd(ra[3:0], b_dig, carry);
  assign fix_res = dadd(r[3:0], 4'd0, carry);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = ADD;
      ADD:     if (last)   state_n = FIX;
      FIX:     if (last)   state_n = FIN;
      FIN:     state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == ADD) || (state == FIX) || (state == FIN);
    done = (state == DONE) || rej_q;
  end

`ifndef BCD_SUB_ADD_MODE_EN
  assign op_q = 1'b0;
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ra      <= '0;
      rb      <= '0;
      r       <= '0;
      idx     <= '0;
      carry   <= 1'b0;
      cout    <= 1'b0;
      rej_q   <= 1'b0;
      diff    <= '0;
      neg     <= 1'b0;
      invalid <= 1'b0;
`ifdef BCD_SUB_ADD_MODE_EN
      op_q    <= 1'b0;
      ovf     <= 1'b0;
`endif
    end else begin
      rej_q <= reject;
      case (state)
        IDLE: begin
          if (accept) begin
            ra    <= a;
            rb    <= b;
            r     <= '0;
            idx   <= '0;
            carry <= 1'b0;
`ifdef BCD_SUB_ADD_MODE_EN
            op_q  <= op;
`endif
          end
          if (reject) begin
            diff    <= '0;
            neg     <= 1'b0;
            invalid <= 1'b1;
`ifdef BCD_SUB_ADD_MODE_EN
            ovf     <= 1'b0;
`endif
          end
        end
        ADD: begin
          ra    <= ra >> 4;
          rb    <= rb >> 4;
          r     <= push_msd(r, add_res[3:0]);
          carry <= add_res[4];
          idx   <= last ? '0 : idx + IW'(1);
          if (last) cout <= add_res[4];
        end
        FIX: begin
          idx <= last ? '0 : idx + IW'(1);
          // Add mode just idles here so both modes share one latency.
          if (!op_q) begin
            if (cout) begin
              r     <= push_msd(r, fix_res[3:0]);
              carry <= fix_res[4];
            end else begin
              r <= push_msd(r, 4'd9 - r[3:0]);
            end
          end
        end
        FIN: begin
          diff    <= r;
          neg     <= !op_q && !cout && (r != '0);
          invalid <= 1'b0;
`ifdef BCD_SUB_ADD_MODE_EN
          ovf     <= op_q && cout;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_sub_serial.sv
// Scoreboard bench for bcd_sub_serial: integer model predicts |a-b|/sign (and a+b/ovf in add mode).
module tb_bcd_sub_serial;
  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;
  localparam int LAT    = 2 * DIGITS + 1;

  logic         clk = 1'b0;
  logic         nrst = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, neg, invalid;
  logic [W-1:0] diff;
`ifdef BCD_SUB_ADD_MODE_EN
  logic         op = 1'b0;
  logic         ovf;
`endif

  int n_checks = 0;
  int errors   = 0;

  typedef struct {
    logic [W-1:0] diff;
    logic         neg;
    logic         inv;
    logic         ovf;
  } exp_t;

  exp_t sbq[$];

  bcd_sub_serial #(.DIGITS(DIGITS)) dut (
    .clk(clk),
    .nrst(nrst),
    .start(start),
`ifdef BCD_SUB_ADD_MODE_EN
    .op(op),
    .ovf(ovf),
`endif
    .a(a),
    .b(b),
    .busy(busy),
    .done(done),
    .diff(diff),
    .neg(neg),
    .invalid(invalid)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic is_bcd(input logic [W-1:0] v);
    for (int i = 0; i < DIGITS; i++)
      if (v[4*i +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int bcd2int(input logic [W-1:0] v);
    int r = 0;
    for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int x);
    logic [W-1:0] v = '0;
    int t = x;
    for (int i = 0; i < DIGITS; i++) begin
      v[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return v;
  endfunction

  function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic opv);
    exp_t e;
    int   x, y, s, m;
    e.diff = '0; e.neg = 1'b0; e.inv = 1'b0; e.ovf = 1'b0;
    if (!is_bcd(av) || !is_bcd(bv)) begin
      e.inv = 1'b1;
      return e;
    end
    x = bcd2int(av);
    y = bcd2int(bv);
    m = 10 ** DIGITS;
    if (opv) begin
      s = x + y;
      e.ovf  = (s >= m);
      e.diff = int2bcd(s % m);
    end else begin
      e.neg  = (x < y);
      e.diff = int2bcd((x < y) ? (y - x) : (x - y));
    end
    return e;
  endfunction

  function automatic logic [W-1:0] rand_bcd();
    logic [W-1:0] v = '0;
    for (int i = 0; i < DIGITS; i++) v[4*i +: 4] = 4'($urandom_range(0, 9));
    return v;
  endfunction

  // Pulse start for one edge; returns #1 after the sampling edge.
  task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv);
    a = av;
    b = bv;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int bcnt);
    lat = 0;
    bcnt = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    n_checks++; if (done !== 1'b0)  begin errors++; $display("FAIL reset_done got=%b want=0", done); end
    n_checks++; if (diff !== '0)    begin errors++; $display("FAIL reset_diff got=%h want=0", diff); end
    n_checks++; if (neg !== 1'b0)   begin errors++; $display("FAIL reset_neg got=%b want=0", neg); end
    n_checks++; if (invalid !== 1'b0) begin errors++; $display("FAIL reset_invalid got=%b want=0", invalid); end
    nrst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_sub();
    logic [W-1:0] va[$];
    logic [W-1:0] vb[$];
    exp_t e;
    int   lat, bcnt;
    va = '{16'h5321, 16'h1234, 16'h0042, 16'h0000, 16'h9999, 16'h0001};
    vb = '{16'h1234, 16'h5321, 16'h0042, 16'h9999, 16'h0000, 16'h1000};
    for (int i = 0; i < 6; i++) begin
      va.push_back(rand_bcd());
      vb.push_back(rand_bcd());
    end
`ifdef BCD_SUB_ADD_MODE_EN
    op = 1'b0;
`endif
    for (int i = 0; i < va.size(); i++) begin
      sbq.push_back(model(va[i], vb[i], 1'b0));
      launch(va[i], vb[i]);
      wait_done(lat, bcnt);
      e = sbq.pop_front();
      n_checks++; if (done !== 1'b1) begin errors++; $display("FAIL sub_timeout a=%h b=%h got done=%b want=1", va[i], vb[i], done); end
      n_checks++; if (lat != LAT) begin errors++; $display("FAIL sub_latency a=%h b=%h got=%0d want=%0d", va[i], vb[i], lat, LAT); end
      n_checks++; if (bcnt != LAT) begin errors++; $display("FAIL sub_busy_cycles a=%h b=%h got=%0d want=%0d", va[i], vb[i], bcnt, LAT); end
      n_checks++; if (diff !== e.diff) begin errors++; $display("FAIL sub_diff a=%h b=%h got=%h want=%h", va[i], vb[i], diff, e.diff); end
      n_checks++; if (neg !== e.neg) begin errors++; $display("FAIL sub_neg a=%h b=%h got=%b want=%b", va[i], vb[i], neg, e.neg); end
      n_checks++; if (invalid !== 1'b0) begin errors++; $display("FAIL sub_invalid a=%h b=%h got=%b want=0", va[i], vb[i], invalid); end
`ifdef BCD_SUB_ADD_MODE_EN
      n_checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL sub_ovf a=%h b=%h got=%b want=0", va[i], vb[i], ovf); end
`endif
      @(posedge clk); #1;
      n_checks++; if (done !== 1'b0) begin errors++; $display("FAIL sub_done_pulse got=%b want=0", done); end
      n_checks++; if (diff !== e.diff) begin errors++; $display("FAIL sub_diff_hold got=%h want=%h", diff, e.diff); end
    end
  endtask

  task automatic test_invalid();
    logic [W-1:0] va[2] = '{16'h12A4, 16'h0001};
    logic [W-1:0] vb[2] = '{16'h0001, 16'h00F0};
    exp_t e;
    int   lat, bcnt, busy_seen;
    for (int i = 0; i < 2; i++) begin
      sbq.push_back(model(va[i], vb[i], 1'b0));
      launch(va[i], vb[i]);
      e = sbq.pop_front();
      n_checks++; if (done !== 1'b1) begin errors++; $display("FAIL inv_done got=%b want=1", done); end
      n_checks++; if (invalid !== e.inv) begin errors++; $display("FAIL inv_flag got=%b want=%b", invalid, e.inv); end
      n_checks++; if (diff !== e.diff) begin errors++; $display("FAIL inv_diff got=%h want=%h", diff, e.diff); end
      n_checks++; if (neg !== e.neg) begin errors++; $display("FAIL inv_neg got=%b want=%b", neg, e.neg); end
      busy_seen = (busy === 1'b1) ? 1 : 0;
      for (int k = 0; k < 4; k++) begin
        @(posedge clk); #1;
        if (busy === 1'b1) busy_seen++;
      end
      n_checks++; if (busy_seen != 0) begin errors++; $display("FAIL inv_busy got=%0d busy cycles want=0", busy_seen); end
      n_checks++; if (done !== 1'b0) begin errors++; $display("FAIL inv_done_pulse got=%b want=0", done); end
    end
    sbq.push_back(model(16'h0010, 16'h0001, 1'b0));
    launch(16'h0010, 16'h0001);
    wait_done(lat, bcnt);
    e = sbq.pop_front();
    n_checks++; if (lat != LAT) begin errors++; $display("FAIL inv_recover_latency got=%0d want=%0d", lat, LAT); end
    n_checks++; if (diff !== e.diff) begin errors++; $display("FAIL inv_recover_diff got=%h want=%h", diff, e.diff); end
    n_checks++; if (invalid !== 1'b0) begin errors++; $display("FAIL inv_recover_flag got=%b want=0", invalid); end
    n_checks++; if (neg !== e.neg) begin errors++; $display("FAIL inv_recover_neg got=%b want=%b", neg, e.neg); end
    @(posedge clk); #1;
  endtask

  task automatic test_abort();
    exp_t e;
    int   lat, bcnt, done_seen;
    launch(16'h9000, 16'h0001);
    @(posedge clk); #1;
    start = 1'b1;
    a = 16'h0005;
    b = 16'h0003;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    nrst = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b want=0", busy); end
    n_checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done got=%b want=0", done); end
    n_checks++; if (diff !== '0) begin errors++; $display("FAIL abort_diff got=%h want=0", diff); end
    n_checks++; if (neg !== 1'b0) begin errors++; $display("FAIL abort_neg got=%b want=0", neg); end
    repeat (2) @(posedge clk);
    #3;
    nrst = 1'b1;
    done_seen = 0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) done_seen++;
    end
    n_checks++; if (done_seen != 0) begin errors++; $display("FAIL abort_no_done got=%0d active cycles want=0", done_seen); end
    sbq.push_back(model(16'h0100, 16'h0001, 1'b0));
    launch(16'h0100, 16'h0001);
    wait_done(lat, bcnt);
    e = sbq.pop_front();
    n_checks++; if (lat != LAT) begin errors++; $display("FAIL abort_recover_latency got=%0d want=%0d", lat, LAT); end
    n_checks++; if (diff !== e.diff) begin errors++; $display("FAIL abort_recover_diff got=%h want=%h", diff, e.diff); end
    n_checks++; if (neg !== e.neg) begin errors++; $display("FAIL abort_recover_neg got=%b want=%b", neg, e.neg); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   lat, bcnt;
    sbq.push_back(model(16'h0777, 16'h0123, 1'b0));
    launch(16'h0777, 16'h0123);
    wait_done(lat, bcnt);
    e = sbq.pop_front();
    n_checks++; if (diff !== e.diff) begin errors++; $display("FAIL b2b_first_diff got=%h want=%h", diff, e.diff); end
    // Next start is raised in the done cycle and held one more cycle.
    sbq.push_back(model(16'h0123, 16'h0777, 1'b0));
    a = 16'h0123;
    b = 16'h0777;
    start = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept got busy=%b want=1", busy); end
    wait_done(lat, bcnt);
    e = sbq.pop_front();
    n_checks++; if (lat != LAT) begin errors++; $display("FAIL b2b_latency got=%0d want=%0d", lat, LAT); end
    n_checks++; if (diff !== e.diff) begin errors++; $display("FAIL b2b_diff got=%h want=%h", diff, e.diff); end
    n_checks++; if (neg !== e.neg) begin errors++; $display("FAIL b2b_neg got=%b want=%b", neg, e.neg); end
    @(posedge clk); #1;
  endtask

`ifdef BCD_SUB_ADD_MODE_EN
  task automatic test_add_mode();
    logic [W-1:0] va[3] = '{16'h9999, 16'h0450, 16'h1234};
    logic [W-1:0] vb[3] = '{16'h0001, 16'h0550, 16'h8765};
    exp_t e;
    int   lat, bcnt;
    for (int i = 0; i < 3; i++) begin
      sbq.push_back(model(va[i], vb[i], 1'b1));
      op = 1'b1;
      launch(va[i], vb[i]);
      op = 1'b0;
      wait_done(lat, bcnt);
      e = sbq.pop_front();
      n_checks++; if (lat != LAT) begin errors++; $display("FAIL add_latency got=%0d want=%0d", lat, LAT); end
      n_checks++; if (diff !== e.diff) begin errors++; $display("FAIL add_diff a=%h b=%h got=%h want=%h", va[i], vb[i], diff, e.diff); end
      n_checks++; if (ovf !== e.ovf) begin errors++; $display("FAIL add_ovf a=%h b=%h got=%b want=%b", va[i], vb[i], ovf, e.ovf); end
      n_checks++; if (neg !== 1'b0) begin errors++; $display("FAIL add_neg got=%b want=0", neg); end
      @(posedge clk); #1;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_sub();
    test_invalid();
    test_abort();
    test_back_to_back();
`ifdef BCD_SUB_ADD_MODE_EN
    test_add_mode();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, errors);
    $finish;
  end

endmodule
